key_conditioner: RTL and testbench
==================================

# key_conditioner

Input-conditioning stage between the board push-buttons and the operand-load/display logic of the lab datapath. It synchronises each active-low raw key, debounces it with a per-key counter FSM, and produces clean one-cycle press, release and auto-repeat strobes plus a stable level. The downstream operand-capture and display stage consumes these outputs instead of the raw asynchronous keys: `key_press` acts as the load strobe and `key_level` selects the display mode.

## Interface
- `NKEYS`, 3 — number of independent key channels.
- `DEBOUNCE_CYCLES`, 500000 — consecutive stable samples required to accept a change (10 ms at 50 MHz); must be ≥ 2.
- `HOLD_CYCLES`, 25000000 — cycles from `key_press` to the first `key_repeat`.
- `REPEAT_CYCLES`, 5000000 — cycles between subsequent `key_repeat` pulses.
- `REPEAT_EN`, 1 — 0 disables `key_repeat` entirely (tied 0).
- `CLOCK_50`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_raw_n`  in  NKEYS  raw push-buttons, asynchronous, 0 = pressed.
- `key_level`  out  NKEYS  debounced state, 1 = pressed.
- `key_press`  out  NKEYS  one-cycle strobe on an accepted press.
- `key_release`  out  NKEYS  one-cycle strobe on an accepted release.
- `key_repeat`  out  NKEYS  one-cycle auto-repeat strobe while held.
- `any_press`  out  1  OR of `key_press`, registered in the same cycle.

## Operation
- Channels are fully independent. Each channel has a 2-FF synchroniser, reset to 1 (released), plus one FSM, one debounce counter and one hold counter.
- FSM states and transitions:
  - RELEASED: synced 0 → DB_PRESS, debounce count = 1.
  - DB_PRESS: synced 1 → RELEASED, no strobe (bounce). Synced 0 and count == DEBOUNCE_CYCLES → PRESSED, pulse `key_press`, set `key_level`, clear hold counter. Otherwise count+1.
  - PRESSED: synced 1 → DB_RELEASE, count = 1. Otherwise the hold counter runs; repeat rules are below.
  - DB_RELEASE: synced 0 → PRESSED (bounce). Hold counter frozen, no strobe. Synced 1 and count == DEBOUNCE_CYCLES → RELEASED, pulse `key_release`, clear `key_level`. Otherwise count+1.
- Repeat, when REPEAT_EN = 1, in PRESSED only:
  - First `key_repeat` fires HOLD_CYCLES cycles after the `key_press` cycle.
  - Each later one fires REPEAT_CYCLES after the previous one.
  - The hold counter saturates; it never wraps to produce a spurious strobe.
- Counter widths are `$clog2` of the largest parameter + 1. Counters never overflow.
- `key_level` is 1 exactly in PRESSED and DB_RELEASE.
- All outputs are registered.

## Timing
- Reset values: all outputs 0, all FSMs RELEASED, synchronisers 1, counters 0.
- Reset is effective immediately on assertion, including mid-debounce or mid-hold; no strobe is emitted on the reset edge.
- Press latency: edge 0 is the first edge sampling `key_raw_n` low.
  - Sync stage 2 is low after edge 1.
  - FSM enters DB_PRESS at edge 2.
  - `key_press` and `key_level` become high after edge 2+DEBOUNCE_CYCLES.
  - `key_press` stays high exactly one cycle.
- Release latency is symmetric: `key_release` is high after edge 2+DEBOUNCE_CYCLES counted from the first high sample.
- Glitches: any low or high excursion shorter than DEBOUNCE_CYCLES samples produces no strobe and no level change.
- Simultaneous events on several channels give strobes in the same cycle. `any_press` matches `key_press` timing.
- A key held low through reset deassertion is treated as a fresh press. Timing is as above, with edge 0 = first edge after deassertion.

## Structure
- Shared package `key_pkg`:
  - FSM state typedef: RELEASED, DB_PRESS, PRESSED, DB_RELEASE.
  - Default timing constants for 50 MHz.
- Sub-module `key_debounce_ch`: one channel containing the synchroniser, FSM and counters, with scalar ports.
- `key_conditioner` generates NKEYS instances and the `any_press` OR-register.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3.
- Clean press: key0 low for 20 cycles, then high → `key_press[0]` one cycle after edge 6; `key_level[0]` high from edge 6; `key_release[0]` six edges after the rise; no other strobes.
- Bounce: key1 low 3 cycles, high 1, low 2, high → zero strobes, `key_level[1]` stays 0; release glitch of 2 cycles while held → no `key_release`.
- Auto-repeat: key2 held 30 cycles with REPEAT_EN=1 → press after edge 6, repeats after edges 14, 17, 20, 23, 26 and up to release detection; with REPEAT_EN=0 → exactly one press, zero repeats.
- Simultaneous: keys 0 and 2 fall on the same cycle → both `key_press` bits and `any_press` high in the same single cycle.
- Reset mid-debounce: assert `rst_n` with key0 in DB_PRESS at count 3 → all outputs 0 immediately; deassert with key0 still low → press after edge 6 post-reset, no strobe during reset.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default 50 MHz timing for the push-button conditioning stage.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_e;

  localparam int unsigned KEY_DEBOUNCE_DEF = 32'd500000;
  localparam int unsigned KEY_HOLD_DEF     = 32'd25000000;
  localparam int unsigned KEY_REPEAT_DEF   = 32'd5000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key-side bundle: raw active-low buttons in, conditioned levels and strobes out.
interface key_conditioner_if #(
  parameter int NKEYS = 3
);
  logic [NKEYS-1:0] key_raw_n;
  logic [NKEYS-1:0] key_level;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;
  logic [NKEYS-1:0] key_repeat;
  logic             any_press;

  modport master (
    output key_raw_n,
    input  key_level, key_press, key_release, key_repeat, any_press
  );

  modport slave (
    input  key_raw_n,
    output key_level, key_press, key_release, key_repeat, any_press
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, hold/auto-repeat counter.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter int unsigned HOLD_CYCLES     = KEY_HOLD_DEF,
  parameter int unsigned REPEAT_CYCLES   = KEY_REPEAT_DEF,
  parameter int unsigned REPEAT_EN       = 32'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic press_next_o
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DB_W    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOLD_W  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_W   = CW'(REPEAT_CYCLES);

  logic          sync1_q, sync2_q;
  key_state_e    state_q;
  logic [CW-1:0] db_cnt_q;
  logic [CW-1:0] hold_cnt_q;
  logic          rep_phase_q;
  logic          level_q, press_q, release_q, repeat_q;
  logic          press_fire_s, release_fire_s, hold_hit_s;

  assign press_fire_s   = (state_q == DB_PRESS)   && !sync2_q && (db_cnt_q == DB_W);
  assign release_fire_s = (state_q == DB_RELEASE) &&  sync2_q && (db_cnt_q == DB_W);
  // The hold counter restarts after every repeat, so it is bounded by the larger target.
  assign hold_hit_s     = ((hold_cnt_q + CNT_ONE) == (rep_phase_q ? REP_W : HOLD_W));

  // Synchroniser, debounce FSM and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= RELEASED;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      rep_phase_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync1_q   <= key_raw_n_i;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (!sync2_q) begin
            state_q  <= DB_PRESS;
            db_cnt_q <= CNT_ONE;
          end
        end
        DB_PRESS: begin
          if (sync2_q) begin
            state_q <= RELEASED;
          end else if (press_fire_s) begin
            state_q     <= PRESSED;
            press_q     <= 1'b1;
            level_q     <= 1'b1;
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync2_q) begin
            state_q  <= DB_RELEASE;
            db_cnt_q <= CNT_ONE;
          end else if (hold_hit_s) begin
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b1;
            repeat_q    <= (REPEAT_EN != 32'd0) ? 1'b1 : 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_ONE;
          end
        end
        DB_RELEASE: begin
          if (!sync2_q) begin
            state_q <= PRESSED;
          end else if (release_fire_s) begin
            state_q   <= RELEASED;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= RELEASED;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign repeat_o     = repeat_q;
  assign press_next_o = press_fire_s;

endmodule

// File: rtl/key_conditioner.sv
// NKEYS independent debounce channels plus a registered OR of the press strobes.
module key_conditioner
  import key_pkg::*;
#(
  parameter int          NKEYS           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter int unsigned HOLD_CYCLES     = KEY_HOLD_DEF,
  parameter int unsigned REPEAT_CYCLES   = KEY_REPEAT_DEF,
  parameter int unsigned REPEAT_EN       = 32'd1
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  key_conditioner_if.slave kif
);

  logic [NKEYS-1:0] level_s, press_s, release_s, repeat_s, press_next_s;
  logic             any_press_q;

  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_ch (
      .clk          (CLOCK_50),
      .rst_n        (rst_n),
      .key_raw_n_i  (kif.key_raw_n[g]),
      .level_o      (level_s[g]),
      .press_o      (press_s[g]),
      .release_o    (release_s[g]),
      .repeat_o     (repeat_s[g]),
      .press_next_o (press_next_s[g])
    );
  end

  // Built from the channels' next-cycle press so it lines up with key_press.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_next_s;
    end
  end

  assign kif.key_level   = level_s;
  assign kif.key_press   = press_s;
  assign kif.key_release = release_s;
  assign kif.key_repeat  = repeat_s;
  assign kif.any_press   = any_press_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench: two DUTs (repeat on/off) against a run-length reference model.
module tb_key_conditioner;

  localparam int NK = 3, DB = 4, HOLD = 8, REP = 3;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_conditioner_if #(.NKEYS(NK)) kif_a ();
  key_conditioner_if #(.NKEYS(NK)) kif_b ();
  assign kif_b.key_raw_n = kif_a.key_raw_n;

  key_conditioner #(.NKEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
                    .REPEAT_CYCLES(REP), .REPEAT_EN(1)) dut_a (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .kif(kif_a));
  key_conditioner #(.NKEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
                    .REPEAT_CYCLES(REP), .REPEAT_EN(0)) dut_b (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .kif(kif_b));

  // Reference: the synced key is the raw sample two edges back; a change is taken after
  // DB+1 consecutive differing samples; repeats fire on held-sample counts HOLD, HOLD+k*REP.
  bit m_s1 [NK] = '{default: 1'b1};
  bit m_s2 [NK] = '{default: 1'b1};
  bit m_lvl[NK] = '{default: 1'b0};
  int m_run[NK] = '{default: 0};
  int m_hold[NK] = '{default: 0};
  bit m_down;
  logic [NK-1:0] e_level = '0, e_press = '0, e_release = '0, e_repeat = '0;

  always @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) begin
        m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_lvl[k] = 1'b0; m_run[k] = 0; m_hold[k] = 0;
      end
      e_level = '0; e_press = '0; e_release = '0; e_repeat = '0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        m_down  = !m_s2[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = kif_a.key_raw_n[k];
        e_press[k] = 1'b0; e_release[k] = 1'b0; e_repeat[k] = 1'b0;
        if (m_down != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k] = m_down;
            m_run[k] = 0;
            if (m_down) begin
              e_press[k] = 1'b1;
              m_hold[k]  = 0;
            end else begin
              e_release[k] = 1'b1;
            end
          end
        end else begin
          if (m_lvl[k] && m_run[k] == 0) begin
            m_hold[k]++;
            if (m_hold[k] == HOLD || (m_hold[k] > HOLD && (m_hold[k] - HOLD) % REP == 0))
              e_repeat[k] = 1'b1;
          end
          m_run[k] = 0;
        end
        e_level[k] = m_lvl[k];
      end
    end
  end

  wire [12:0] obs_a = {kif_a.key_level, kif_a.key_press, kif_a.key_release,
                       kif_a.key_repeat, kif_a.any_press};
  wire [12:0] obs_b = {kif_b.key_level, kif_b.key_press, kif_b.key_release,
                       kif_b.key_repeat, kif_b.any_press};
  wire [12:0] exp_a = {e_level, e_press, e_release, e_repeat, |e_press};
  wire [12:0] exp_b = {e_level, e_press, e_release, 3'b000, |e_press};

  task automatic idle(input int n);
    kif_a.key_raw_n = 3'b111;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    kif_a.key_raw_n = 3'b111;
    rst_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (obs_a !== 13'd0) begin failures++; $display("FAIL reset_a got=%b want=0", obs_a); end
    checks++;
    if (obs_b !== 13'd0) begin failures++; $display("FAIL reset_b got=%b want=0", obs_b); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_clean_press();
    int press_at = -1, rel_at = -1, lvl_at = -1, n_press = 0, n_rel = 0, n_other = 0;
    for (int c = 0; c < 36; c++) begin
      kif_a.key_raw_n = (c < 20) ? 3'b110 : 3'b111;
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== exp_a) begin failures++; $display("FAIL clean_model_a c=%0d got=%b want=%b", c, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin failures++; $display("FAIL clean_model_b c=%0d got=%b want=%b", c, obs_b, exp_b); end
      if (kif_a.key_press[0])   begin n_press++; press_at = c; end
      if (kif_a.key_release[0]) begin n_rel++;   rel_at = c;   end
      if (kif_a.key_level[0] && lvl_at < 0) lvl_at = c;
      if (|{kif_a.key_press[2:1], kif_a.key_release[2:1], kif_a.key_repeat[2:1]}) n_other++;
    end
    checks++;
    if (n_press != 1 || press_at != 6) begin failures++; $display("FAIL clean_press n=%0d at=%0d want n=1 at=6", n_press, press_at); end
    checks++;
    if (lvl_at != 6) begin failures++; $display("FAIL clean_level first=%0d want=6", lvl_at); end
    checks++;
    if (n_rel != 1 || rel_at != 26) begin failures++; $display("FAIL clean_release n=%0d at=%0d want n=1 at=26", n_rel, rel_at); end
    checks++;
    if (n_other != 0) begin failures++; $display("FAIL clean_other got=%0d want=0", n_other); end
    idle(4);
  endtask

  task automatic test_bounce();
    int n_press = 0, n_rel = 0, rel_at = -1, lvl_seen = 0;
    for (int c = 0; c < 16; c++) begin
      kif_a.key_raw_n = (c < 3 || c == 4 || c == 5) ? 3'b101 : 3'b111;
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== exp_a) begin failures++; $display("FAIL bounce_model_a c=%0d got=%b want=%b", c, obs_a, exp_a); end
      if (kif_a.key_press[1] || kif_a.key_release[1]) n_press++;
      if (kif_a.key_level[1]) lvl_seen++;
    end
    checks++;
    if (n_press != 0 || lvl_seen != 0) begin failures++; $display("FAIL bounce_press strobes=%0d level=%0d want 0 0", n_press, lvl_seen); end
    n_press = 0;
    for (int c = 0; c < 50; c++) begin
      kif_a.key_raw_n = (c < 20 || (c >= 22 && c < 34)) ? 3'b101 : 3'b111;
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== exp_a) begin failures++; $display("FAIL glitch_model_a c=%0d got=%b want=%b", c, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin failures++; $display("FAIL glitch_model_b c=%0d got=%b want=%b", c, obs_b, exp_b); end
      if (kif_a.key_press[1])   n_press++;
      if (kif_a.key_release[1]) begin n_rel++; rel_at = c; end
    end
    checks++;
    if (n_press != 1 || n_rel != 1 || rel_at != 40) begin
      failures++; $display("FAIL glitch_release press=%0d rel=%0d at=%0d want 1 1 40", n_press, n_rel, rel_at);
    end
    idle(4);
  endtask

  task automatic test_repeat();
    int want[6] = '{14, 17, 20, 23, 26, 29};
    int got[$];
    int n_rep_b = 0, n_press_b = 0;
    for (int c = 0; c < 44; c++) begin
      kif_a.key_raw_n = (c < 30) ? 3'b011 : 3'b111;
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== exp_a) begin failures++; $display("FAIL repeat_model_a c=%0d got=%b want=%b", c, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin failures++; $display("FAIL repeat_model_b c=%0d got=%b want=%b", c, obs_b, exp_b); end
      if (kif_a.key_repeat[2]) got.push_back(c);
      if (kif_b.key_repeat[2]) n_rep_b++;
      if (kif_b.key_press[2])  n_press_b++;
    end
    checks++;
    if (got.size() != 6) begin failures++; $display("FAIL repeat_count got=%0d want=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] != want[i]) begin failures++; $display("FAIL repeat_edge i=%0d got=%0d want=%0d", i, got[i], want[i]); end
    end
    checks++;
    if (n_rep_b != 0 || n_press_b != 1) begin failures++; $display("FAIL repeat_disabled rep=%0d press=%0d want 0 1", n_rep_b, n_press_b); end
    idle(4);
  endtask

  task automatic test_simultaneous();
    int both_at = -1, n_any = 0, any_at = -1;
    for (int c = 0; c < 24; c++) begin
      kif_a.key_raw_n = (c < 10) ? 3'b010 : 3'b111;
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== exp_a) begin failures++; $display("FAIL simul_model_a c=%0d got=%b want=%b", c, obs_a, exp_a); end
      if (kif_a.key_press[0] && kif_a.key_press[2]) both_at = c;
      if (kif_a.any_press) begin n_any++; any_at = c; end
    end
    checks++;
    if (both_at != 6 || n_any != 1 || any_at != 6) begin
      failures++; $display("FAIL simul_press both=%0d any_n=%0d any_at=%0d want 6 1 6", both_at, n_any, any_at);
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    int press_at = -1, n_press = 0;
    for (int c = 0; c < 5; c++) begin
      kif_a.key_raw_n = 3'b110;
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== exp_a) begin failures++; $display("FAIL rstmid_model_a c=%0d got=%b want=%b", c, obs_a, exp_a); end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== 13'd0 || obs_b !== 13'd0) begin failures++; $display("FAIL rstmid_immediate got=%b/%b want=0", obs_a, obs_b); end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== 13'd0) begin failures++; $display("FAIL rstmid_hold c=%0d got=%b want=0", c, obs_a); end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== exp_a) begin failures++; $display("FAIL rstmid_after_a c=%0d got=%b want=%b", c, obs_a, exp_a); end
      if (kif_a.key_press[0]) begin n_press++; press_at = c; end
    end
    checks++;
    if (n_press != 1 || press_at != 6) begin failures++; $display("FAIL rstmid_press n=%0d at=%0d want 1 6", n_press, press_at); end
    idle(10);
  endtask

  task automatic test_random();
    int left[NK];
    logic [NK-1:0] raw = 3'b111;
    for (int k = 0; k < NK; k++) left[k] = $urandom_range(1, 12);
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NK; k++) begin
        left[k]--;
        if (left[k] == 0) begin
          raw[k]  = ~raw[k];
          left[k] = $urandom_range(1, 12);
        end
      end
      kif_a.key_raw_n = raw;
      @(negedge CLOCK_50);
      checks++;
      if (obs_a !== exp_a) begin failures++; $display("FAIL random_model_a c=%0d got=%b want=%b", c, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin failures++; $display("FAIL random_model_b c=%0d got=%b want=%b", c, obs_b, exp_b); end
    end
    idle(12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kif_a.key_raw_n = 3'b111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
